// File: rtl/apb_slave_memory.sv
// APB4 completer backed by a word-addressed register memory.
// Supports fixed wait-state insertion, byte-strobed writes, and PSLVERR on
// out-of-range, misaligned, illegal-strobe or non-secure accesses.
module apb_slave_memory #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              MEM_DEPTH     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int unsigned              WAIT_STATES   = 0,
    parameter bit                       SECURE_ONLY   = 1'b0
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       pselx,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDRESS_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]      pwdata,
    input  logic [DATA_WIDTH/8-1:0]    pstrb,
    input  logic [2:0]                 pprot,
    output logic                       pready,
    output logic [DATA_WIDTH-1:0]      prdata,
    output logic                       pslverr
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned BYTE_OFF  = $clog2(STRB_W);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_BYTES = MEM_DEPTH * STRB_W;
    // One extra bit so BASE_ADDR + size cannot wrap at the top of the space.
    localparam logic [ADDRESS_WIDTH:0]   LIMIT      = {1'b0, BASE_ADDR} + (ADDRESS_WIDTH+1)'(MEM_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(STRB_W - 1);
    localparam logic [3:0]               WAIT_LOAD  = 4'(WAIT_STATES);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_err;
    logic                    r_pready;
    logic                    r_pslverr;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    state_t                  w_state_nxt;
    logic [3:0]              w_cnt_nxt;
    logic                    w_write_nxt;
    logic [DATA_WIDTH-1:0]   w_wdata_nxt;
    logic [STRB_W-1:0]       w_strb_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_err_nxt;
    logic                    w_pready_nxt;
    logic                    w_pslverr_nxt;
    logic [DATA_WIDTH-1:0]   w_prdata_nxt;
    logic                    w_mem_we;

    logic                    w_setup;
    logic [ADDRESS_WIDTH-1:0] w_offset;
    logic [IDX_W-1:0]        w_idx_live;
    logic                    w_err_live;
    logic                    w_unused_prot;

    // Decode of the live bus used when a setup phase is accepted.
    assign w_setup    = pselx & ~penable;
    assign w_offset   = paddr - BASE_ADDR;
    assign w_idx_live = IDX_W'(w_offset >> BYTE_OFF);
    assign w_err_live = ({1'b0, paddr} < {1'b0, BASE_ADDR})
                      | ({1'b0, paddr} >= LIMIT)
                      | ((paddr & ALIGN_MASK) != '0)
                      | (~pwrite & (pstrb != '0))
                      | (SECURE_ONLY & pprot[1]);
    assign w_unused_prot = pprot[0] ^ pprot[2];

    // Next-state, transfer capture and registered-output precompute.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_write_nxt = r_write;
        w_wdata_nxt = r_wdata;
        w_strb_nxt  = r_strb;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err;
        w_mem_we    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = WAIT_LOAD;
                    w_write_nxt = pwrite;
                    w_wdata_nxt = pwdata;
                    w_strb_nxt  = pstrb;
                    w_idx_nxt   = w_idx_live;
                    w_err_nxt   = w_err_live;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    // Completion cycle is on the bus now; retire at this edge.
                    w_state_nxt = ST_IDLE;
                    w_mem_we    = r_write & ~r_err;
                end else if (pselx & penable) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    // Requester abandoned the transfer before completion.
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_pready_nxt  = (w_state_nxt == ST_ACCESS) && (w_cnt_nxt == 4'd0);
        w_pslverr_nxt = w_pready_nxt & w_err_nxt;
        w_prdata_nxt  = (w_pready_nxt & ~w_write_nxt & ~w_err_nxt) ? r_mem[w_idx_nxt] : '0;
    end

    // State, captured transfer and output registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_write   <= w_write_nxt;
            r_wdata   <= w_wdata_nxt;
            r_strb    <= w_strb_nxt;
            r_idx     <= w_idx_nxt;
            r_err     <= w_err_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
        end
    end

    // Memory array: cleared on reset, byte-lane merge on a clean write completion.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (r_strb[b]) begin
                    r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign pready  = r_pready;
    assign prdata  = r_prdata;
    assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_memory.sv
// Directed bench for apb_slave_memory: three instances with different wait
// states / base / security, a transaction-level memory model, and one
// per-cycle compare process that checks every output of every instance.
module tb_apb_slave_memory;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance configuration as seen by the model.
    int unsigned       ws_of   [N] = '{0, 3, 2};
    bit                sec_of  [N] = '{1'b0, 1'b1, 1'b0};
    logic [31:0]       base_of [N] = '{32'h0, 32'h1000, 32'h0};

    logic        rstn [N];
    logic        psel [N];
    logic        pen  [N];
    logic        pwr  [N];
    logic [31:0] pa   [N];
    logic [31:0] pwd  [N];
    logic [3:0]  ps   [N];
    logic [2:0]  pp   [N];
    logic        rdy  [N];
    logic [31:0] rd   [N];
    logic        err  [N];

    logic        e_rdy [N];
    logic [31:0] e_rd  [N];
    logic        e_err [N];
    logic [31:0] last_rd [N];
    logic [31:0] mdl [N][16];

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;

    apb_slave_memory #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16),
        .BASE_ADDR(32'h0), .WAIT_STATES(0), .SECURE_ONLY(1'b0)) u_dut0 (
        .pclk(clk), .presetn(rstn[0]), .pselx(psel[0]), .penable(pen[0]),
        .pwrite(pwr[0]), .paddr(pa[0]), .pwdata(pwd[0]), .pstrb(ps[0]),
        .pprot(pp[0]), .pready(rdy[0]), .prdata(rd[0]), .pslverr(err[0]));

    apb_slave_memory #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16),
        .BASE_ADDR(32'h1000), .WAIT_STATES(3), .SECURE_ONLY(1'b1)) u_dut1 (
        .pclk(clk), .presetn(rstn[1]), .pselx(psel[1]), .penable(pen[1]),
        .pwrite(pwr[1]), .paddr(pa[1]), .pwdata(pwd[1]), .pstrb(ps[1]),
        .pprot(pp[1]), .pready(rdy[1]), .prdata(rd[1]), .pslverr(err[1]));

    apb_slave_memory #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16),
        .BASE_ADDR(32'h0), .WAIT_STATES(2), .SECURE_ONLY(1'b0)) u_dut2 (
        .pclk(clk), .presetn(rstn[2]), .pselx(psel[2]), .penable(pen[2]),
        .pwrite(pwr[2]), .paddr(pa[2]), .pwdata(pwd[2]), .pstrb(ps[2]),
        .pprot(pp[2]), .pready(rdy[2]), .prdata(rd[2]), .pslverr(err[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("pready[%0d]", i),  32'(rdy[i]), 32'(e_rdy[i]));
                check($sformatf("pslverr[%0d]", i), 32'(err[i]), 32'(e_err[i]));
                check($sformatf("prdata[%0d]", i),  rd[i], e_rd[i]);
                if (rdy[i] === 1'b1) last_rd[i] <= rd[i];
            end
        end
    end

    task automatic clr_exp(input int id);
        e_rdy[id] = 1'b0;
        e_err[id] = 1'b0;
        e_rd[id]  = 32'h0;
    endtask

    task automatic bus_idle(input int id);
        psel[id] = 1'b0;
        pen[id]  = 1'b0;
        clr_exp(id);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer. cut_after>0 ends it after that many access cycles,
    // either by dropping pselx (abort) or by pulsing reset (cut_rst).
    task automatic xfer(input int id, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] pr, input int cut_after, input bit cut_rst);
        bit e;
        int idx;
        int unsigned last;
        logic [31:0] w;
        e = (a < base_of[id]) || (a >= base_of[id] + 32'd64) || (a[1:0] != 2'b00)
            || (!wr && s != 4'h0) || (sec_of[id] && pr[1]);
        idx  = int'((a - base_of[id]) >> 2) & 15;
        last = ws_of[id] + 1;
        // Setup phase
        psel[id] = 1'b1; pen[id] = 1'b0; pwr[id] = wr;
        pa[id] = a; pwd[id] = d; ps[id] = s; pp[id] = pr;
        clr_exp(id);
        step();
        pen[id] = 1'b1;
        for (int unsigned j = 1; j <= last; j++) begin
            if (cut_after > 0 && j == 32'(cut_after + 1)) begin
                bus_idle(id);
                if (cut_rst) rstn[id] = 1'b0;
                step();
                if (cut_rst) begin
                    rstn[id] = 1'b1;
                    for (int k = 0; k < 16; k++) mdl[id][k] = 32'h0;
                end
                return;
            end
            if (j == last) begin
                e_rdy[id] = 1'b1;
                e_err[id] = e;
                e_rd[id]  = (!wr && !e) ? mdl[id][idx] : 32'h0;
            end
            step();
        end
        if (wr && !e) begin
            w = mdl[id][idx];
            for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
            mdl[id][idx] = w;
        end
        bus_idle(id);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rstn[i] = 1'b0; pwr[i] = 1'b0; pa[i] = 32'h0; pwd[i] = 32'h0;
            ps[i] = 4'h0; pp[i] = 3'b000; last_rd[i] = 32'h0;
            bus_idle(i);
            for (int k = 0; k < 16; k++) mdl[i][k] = 32'h0;
        end
        step();
        step();
        chk_en = 1'b1;           // reset values are checked from here
        step();
        for (int i = 0; i < N; i++) rstn[i] = 1'b1;
        step();

        // Zero wait: write then back-to-back read
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b000, 0, 1'b0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        check("lit_rd_0x04", last_rd[0], 32'hDEADBEEF);

        // Partial strobe merge and strobe-0 no-op write
        xfer(0, 1'b1, 32'h08, 32'h11223344, 4'hF, 3'b000, 0, 1'b0);
        xfer(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 3'b000, 0, 1'b0);
        check("lit_mdl_0x08", mdl[0][2], 32'h11BB33DD);
        xfer(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 3'b000, 0, 1'b0);
        step();
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        check("lit_rd_0x08", last_rd[0], 32'h11BB33DD);

        // Error cases: out of range, misaligned write, read with strobes
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        xfer(0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 3'b000, 0, 1'b0);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        check("lit_rd_0x00_untouched", last_rd[0], 32'h0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h1, 3'b000, 0, 1'b0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 0, 1'b0);

        // Last word, and penable without a setup phase is ignored
        xfer(0, 1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 3'b000, 0, 1'b0);
        psel[0] = 1'b1; pen[0] = 1'b1; pwr[0] = 1'b0; pa[0] = 32'h3C; ps[0] = 4'h0;
        step();
        step();
        bus_idle(0);
        step();
        xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        check("lit_rd_0x3C", last_rd[0], 32'hCAFEF00D);

        // Three wait states, non-zero base, secure-only
        xfer(1, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 3'b000, 0, 1'b0);
        xfer(1, 1'b0, 32'h1000, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        check("lit_rd_1000", last_rd[1], 32'hA5A5A5A5);
        xfer(1, 1'b0, 32'h1000, 32'h0, 4'h0, 3'b010, 0, 1'b0);
        xfer(1, 1'b1, 32'h1000, 32'h0, 4'hF, 3'b010, 0, 1'b0);
        xfer(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        xfer(1, 1'b0, 32'h1040, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        xfer(1, 1'b0, 32'h103C, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        xfer(1, 1'b0, 32'h1000, 32'h0, 4'h0, 3'b001, 0, 1'b0);
        check("lit_rd_1000_secure_kept", last_rd[1], 32'hA5A5A5A5);

        // Abort after the first access cycle leaves memory unchanged
        xfer(2, 1'b1, 32'h0C, 32'h12345678, 4'hF, 3'b000, 0, 1'b0);
        xfer(2, 1'b1, 32'h0C, 32'h00000055, 4'hF, 3'b000, 1, 1'b0);
        step();
        xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        check("lit_rd_0C_after_abort", last_rd[2], 32'h12345678);

        // Reset during an access clears memory and drops the write
        for (int k = 0; k < 16; k++)
            xfer(2, 1'b1, 32'(k * 4), 32'h01010101 * 32'(k + 1), 4'hF, 3'b000, 0, 1'b0);
        xfer(2, 1'b1, 32'h10, 32'h77777777, 4'hF, 3'b000, 1, 1'b1);
        step();
        for (int k = 0; k < 16; k++)
            xfer(2, 1'b0, 32'(k * 4), 32'h0, 4'h0, 3'b000, 0, 1'b0);
        check("lit_rd_after_reset", last_rd[2], 32'h0);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
